// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// DATA at +0x0 pushes bytes, STATUS at +0x4 reports FIFO/serializer state.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_wstrobe,
  input  logic        mem_rstrobe,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        uart_tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          tx_q;

  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          ovf_q;
  logic          ovf_d;
  logic          done_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;

  logic          hit;
  logic          wr_hit;
  logic          rd_hit;
  logic [1:0]    reg_sel;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          busy;
  logic          bit_end;
  logic [AW:0]   count;
  logic [31:0]   cnt32;
  logic [3:0]    cnt4;
  logic [31:0]   status;
  logic [7:0]    head;
  logic          unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8], mem_wmask[3:1]};

  assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit  = hit & mem_wstrobe;
  assign rd_hit  = hit & mem_rstrobe;
  assign reg_sel = mem_addr[3:2];

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign bit_end = (cnt_q == '0);
  // A pop happens from IDLE, or from the last STOP cycle to chain frames.
  assign pop = !empty &&
               ((state_q == S_IDLE) ||
                ((state_q == S_STOP) && bit_end));

  assign push_req = wr_hit && (reg_sel == 2'd0) && mem_wmask[0];
  assign push     = push_req && !full;

  assign ovf_d = (push_req && full) ||
                 (ovf_q && !(wr_hit && (reg_sel == 2'd1) &&
                             mem_wmask[0] && mem_wdata[3]));

  assign busy = (state_q != S_IDLE) || !empty;

  assign cnt32  = 32'(count);
  assign cnt4   = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];
  assign status = {24'h0, cnt4, ovf_q, busy, empty, full};

  always_comb begin
    rdata_d = '0;
    if (rd_hit && (reg_sel == 2'd1)) rdata_d = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      done_q  <= wr_hit | rd_hit;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            cnt_q   <= DIV_M1;
            sh_q    <= head;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= DIV_M1;
            bit_q   <= '0;
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= DIV_M1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              state_q <= S_START;
              cnt_q   <= DIV_M1;
              sh_q    <= head;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_done  = done_q;
  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;
  assign irq_empty = !busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: line samples are decoded into frames
// and compared with byte queues built from the register rules.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;
  localparam int LMAX  = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_wstrobe = 1'b0;
  logic        mem_rstrobe = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        uart_tx;
  logic        irq_empty;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_wstrobe(mem_wstrobe),
    .mem_rstrobe(mem_rstrobe),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .uart_tx    (uart_tx),
    .irq_empty  (irq_empty)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic line_a [LMAX];
  logic irq_a  [LMAX];
  int   cyc = 0;
  int   rx_q [$];
  int   rxs_q [$];

  logic        d1, d2;
  logic [31:0] r1, r2;
  int          at;

  initial forever begin
    @(negedge clk);
    if (cyc < LMAX) begin
      line_a[cyc] = uart_tx;
      irq_a[cyc]  = irq_empty;
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic bus(input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m,
                     output logic done, output logic [31:0] rd,
                     output logic done2, output logic [31:0] rd2,
                     output int t);
    @(posedge clk); #1;
    mem_addr    = a;
    mem_wdata   = d;
    mem_wmask   = m;
    mem_wstrobe = wr;
    mem_rstrobe = ~wr;
    @(posedge clk); #1;
    mem_wstrobe = 1'b0;
    mem_rstrobe = 1'b0;
    mem_addr    = $urandom;
    mem_wdata   = $urandom;
    done = mem_done;
    rd   = mem_rdata;
    t    = cyc;
    @(posedge clk); #1;
    done2 = mem_done;
    rd2   = mem_rdata;
  endtask

  function automatic void decode(input int from, input int upto);
    int i;
    int v;
    bit ok;
    rx_q.delete();
    rxs_q.delete();
    i = from;
    while (i + FRAME <= upto) begin
      if (line_a[i] === 1'b0) begin
        ok = 1'b1;
        v  = 0;
        for (int s = 0; s < 10; s++)
          for (int j = 0; j < DIV; j++)
            if (line_a[i+s*DIV+j] !== line_a[i+s*DIV]) ok = 1'b0;
        if (line_a[i+9*DIV] !== 1'b1) ok = 1'b0;
        for (int k = 0; k < 8; k++)
          if (line_a[i+(k+1)*DIV] === 1'b1) v |= (1 << k);
        rx_q.push_back(ok ? v : -1);
        rxs_q.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_tx: got %b want 1", uart_tx);
    end
    n_tests++;
    if (mem_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done: got %b want 0", mem_done);
    end
    n_tests++;
    if (mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h want 0", mem_rdata);
    end
    n_tests++;
    if (irq_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_irq: got %b want 1", irq_empty);
    end
    @(negedge clk);
    rst = 1'b0;
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (d1 !== 1'b1 || r1 !== 32'h2) begin
      n_fail++;
      $display("FAIL rst_status: got done=%b %h want 1 2", d1, r1);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] bytes [3];
    logic       e;
    int         errs;
    int         slot;
    bytes[0] = 8'h55;
    bytes[1] = 8'($urandom);
    bytes[2] = 8'($urandom);
    foreach (bytes[n]) begin
      bus(1, BASE, {24'($urandom), bytes[n]}, 4'h1, d1, r1, d2, r2, at);
      n_tests++;
      if (d1 !== 1'b1 || d2 !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_done: got %b%b want 10", d1, d2);
      end
      repeat (FRAME + 6) @(posedge clk);
      errs = 0;
      for (int t = 0; t <= FRAME + 1; t++) begin
        if (t == 0 || t > FRAME) begin
          e = 1'b1;
        end else begin
          slot = (t - 1) / DIV;
          if (slot == 0)      e = 1'b0;
          else if (slot == 9) e = 1'b1;
          else                e = bytes[n][slot-1];
        end
        if (line_a[at+t] !== e) errs++;
      end
      n_tests++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL frame_wave %h: got %0d bad cycles want 0",
                 bytes[n], errs);
      end
      n_tests++;
      if (irq_a[at+FRAME] !== 1'b0 || irq_a[at+FRAME+1] !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_irq: got %b%b want 01",
                 irq_a[at+FRAME], irq_a[at+FRAME+1]);
      end
    end
  endtask

  task automatic test_overflow();
    int         exp_q [$];
    int         occ;
    bit         ovf;
    int         at0;
    int         bad;
    int         dn;
    logic [7:0] v;
    logic [31:0] exp_st;
    v = 8'($urandom);
    bus(1, BASE, {24'h0, v}, 4'h1, d1, r1, d2, r2, at0);
    exp_q.push_back(int'(v));
    occ = 0;
    ovf = 1'b0;
    dn  = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 8'($urandom);
      bus(1, BASE, {24'($urandom), v}, 4'h1, d1, r1, d2, r2, at);
      if (d1 === 1'b1) dn++;
      if (occ < DEPTH) begin
        occ++;
        exp_q.push_back(int'(v));
      end else begin
        ovf = 1'b1;
      end
    end
    n_tests++;
    if (dn != DEPTH + 1) begin
      n_fail++;
      $display("FAIL ovf_wr_done: got %0d want %0d", dn, DEPTH + 1);
    end
    exp_st = 32'(occ << 4) | (32'(ovf) << 3) | 32'h4 |
             (occ == 0 ? 32'h2 : 32'h0) |
             (occ == DEPTH ? 32'h1 : 32'h0);
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== exp_st) begin
      n_fail++;
      $display("FAIL ovf_status: got %h want %h", r1, exp_st);
    end
    repeat (exp_q.size() * FRAME + 20) @(posedge clk);
    decode(at0, cyc);
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL ovf_nframes: got %0d want %0d",
               rx_q.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i])
      if (i >= rx_q.size() || rx_q[i] != exp_q[i]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ovf_bytes: got %0d wrong want 0", bad);
    end
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== 32'h0A) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %h want 0a", r1);
    end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] w;
    w = $urandom & ~32'h8;
    bus(1, BASE + 32'h4, w, 4'h1, d1, r1, d2, r2, at);
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== 32'h0A) begin
      n_fail++;
      $display("FAIL clr_bit3_zero: got %h want 0a", r1);
    end
    bus(1, BASE + 32'h4, 32'h8, 4'hE, d1, r1, d2, r2, at);
    n_tests++;
    if (d1 !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_masked_done: got %b want 1", d1);
    end
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== 32'h0A) begin
      n_fail++;
      $display("FAIL clr_masked: got %h want 0a", r1);
    end
    bus(1, BASE + 32'h4, 32'h8, 4'h1, d1, r1, d2, r2, at);
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== 32'h02) begin
      n_fail++;
      $display("FAIL clr_ovf: got %h want 02", r1);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q [$];
    int at0;
    int bad;
    int ls;
    int hi;
    logic [7:0] v;
    for (int r = 0; r < 2; r++) begin
      exp_q.delete();
      for (int i = 0; i < r + 2; i++) begin
        if (r == 0) v = (i == 0) ? 8'hA1 : 8'hB2;
        else        v = 8'($urandom);
        bus(1, BASE, {24'h0, v}, 4'h1, d1, r1, d2, r2, at);
        if (i == 0) at0 = at;
        exp_q.push_back(int'(v));
      end
      repeat (exp_q.size() * FRAME + 10) @(posedge clk);
      decode(at0, cyc);
      bad = 0;
      if (rx_q.size() != exp_q.size()) bad++;
      foreach (exp_q[i]) begin
        if (i >= rx_q.size()) bad++;
        else begin
          if (rx_q[i] != exp_q[i]) bad++;
          if (rxs_q[i] != at0 + 1 + i * FRAME) bad++;
        end
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL b2b_frames r%0d: got %0d errors want 0", r, bad);
      end
      ls = at0 + 1 + (exp_q.size() - 1) * FRAME;
      hi = 0;
      for (int t = at0; t < ls + FRAME; t++)
        if (irq_a[t] !== 1'b0) hi++;
      n_tests++;
      if (hi != 0 || irq_a[ls+FRAME] !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_irq r%0d: got early=%0d end=%b want 0 1",
                 r, hi, irq_a[ls+FRAME]);
      end
    end
  endtask

  task automatic test_decode();
    int at0;
    int dn;
    bus(1, BASE + 32'h10, 32'h5A, 4'h1, d1, r1, d2, r2, at0);
    n_tests++;
    if (d1 !== 1'b0 || d2 !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_wr_done: got %b%b want 00", d1, d2);
    end
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      bus(0, BASE ^ (32'($urandom_range(1, 255)) << 4) ^ 32'h4,
          32'h0, 4'h0, d1, r1, d2, r2, at);
      if (d1 !== 1'b0 || r1 !== 32'h0) dn++;
    end
    n_tests++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL miss_rd: got %0d responses want 0", dn);
    end
    mem_rdata_chk: begin
      bus(0, BASE + 32'h8, 32'h0, 4'h0, d1, r1, d2, r2, at);
      n_tests++;
      if (d1 !== 1'b1 || r1 !== 32'h0 ||
          d2 !== 1'b0 || r2 !== 32'h0) begin
        n_fail++;
        $display("FAIL rsv_rd: got %b %h %b %h want 1 0 0 0",
                 d1, r1, d2, r2);
      end
    end
    bus(1, BASE + 32'hC, $urandom, 4'hF, d1, r1, d2, r2, at);
    n_tests++;
    if (d1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rsv_wr_done: got %b want 1", d1);
    end
    bus(0, BASE, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (d1 !== 1'b1 || r1 !== 32'h0) begin
      n_fail++;
      $display("FAIL data_rd: got %b %h want 1 0", d1, r1);
    end
    bus(1, BASE, 32'h3C, 4'hE, d1, r1, d2, r2, at);
    n_tests++;
    if (d1 !== 1'b1) begin
      n_fail++;
      $display("FAIL nomask_done: got %b want 1", d1);
    end
    bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
    n_tests++;
    if (r1 !== 32'h02) begin
      n_fail++;
      $display("FAIL dec_status: got %h want 02", r1);
    end
    repeat (FRAME + 10) @(posedge clk);
    decode(at0, cyc);
    n_tests++;
    if (rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL dec_noframe: got %0d frames want 0", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int r;
    int z;
    for (int c = 0; c < 2; c++) begin
      v = 8'($urandom);
      if (c == 0) begin
        bus(1, BASE, 32'hFF, 4'h1, d1, r1, d2, r2, at);
        bus(1, BASE, {24'h0, v}, 4'h1, d1, r1, d2, r2, at);
        repeat (6) @(posedge clk);
      end else begin
        bus(1, BASE, {24'h0, v}, 4'h1, d1, r1, d2, r2, at);
        @(posedge clk);
      end
      #3;
      n_tests++;
      if (uart_tx !== (c == 0)) begin
        n_fail++;
        $display("FAIL pre_rst_tx c%0d: got %b want %b",
                 c, uart_tx, c == 0);
      end
      rst         = 1'b1;
      mem_addr    = BASE;
      mem_wdata   = $urandom;
      mem_wmask   = 4'h1;
      mem_wstrobe = 1'b1;
      #1;
      n_tests++;
      if (uart_tx !== 1'b1 || irq_empty !== 1'b1 || mem_done !== 1'b0) begin
        n_fail++;
        $display("FAIL async_rst c%0d: got tx=%b irq=%b done=%b want 1 1 0",
                 c, uart_tx, irq_empty, mem_done);
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      rst         = 1'b0;
      mem_wstrobe = 1'b0;
      r = cyc;
      bus(0, BASE + 32'h4, 32'h0, 4'h0, d1, r1, d2, r2, at);
      n_tests++;
      if (d1 !== 1'b1 || r1 !== 32'h2) begin
        n_fail++;
        $display("FAIL post_rst_status c%0d: got %b %h want 1 2",
                 c, d1, r1);
      end
      repeat (3 * FRAME) @(posedge clk);
      decode(r, cyc);
      z = 0;
      for (int t = r; t < cyc; t++)
        if (line_a[t] !== 1'b1) z++;
      n_tests++;
      if (rx_q.size() != 0 || z != 0) begin
        n_fail++;
        $display("FAIL post_rst_line c%0d: got %0d frames %0d low want 0 0",
                 c, rx_q.size(), z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_ovf_clear();
    test_back_to_back();
    test_decode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
